proc_control_unit: RTL and testbench

PROC_CONTROL_UNIT -- requirements
Module: proc_control_unit

---
 rtl/proc_control_unit.sv | 137 +++++++++++++
 tb/tb_proc_control_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// Control unit for a simple multi-cycle processor.
// It fetches one 9-bit instruction {III,XXX,YYY} in T0 and sequences the
// register-file, A, G and bus strobes over T1..T3. The outputs are decoded
// from the cycle state and the IR, except IRin, which also depends on Run.

module proc_control_unit (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] DIN,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       DINout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       AddSub,
  output logic       Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_e     state_q;
  state_e     state_d;
  logic [8:0] ir_q;
  logic [8:0] ir_d;

  logic [2:0] op_s;
  logic [2:0] rx_s;
  logic [2:0] ry_s;

  assign op_s = ir_q[8:6];
  assign rx_s = ir_q[5:3];
  assign ry_s = ir_q[2:0];

  // Register-select decoder: a 3-bit register number becomes a one-hot enable.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'd1 << idx;
  endfunction

  // Cycle state and instruction register; Reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= 9'h000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic and output decode for each cycle of the instruction.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    IRin    = 1'b0;
    Rin     = 8'h00;
    Rout    = 8'h00;
    DINout  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;

    case (state_q)
      T0: begin
        // Fetch: the IR only ever loads here, so later DIN changes cannot alter it.
        if (Run) begin
          IRin    = ~Reset;
          ir_d    = DIN;
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end

      T1: begin
        case (op_s)
          OP_MV: begin
            Rout    = onehot8(ry_s);
            Rin     = onehot8(rx_s);
            Done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            Rin     = onehot8(rx_s);
            Done    = 1'b1;
            state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            Rout    = onehot8(rx_s);
            Ain     = 1'b1;
            state_d = T2;
          end
          default: begin
            // Undefined opcodes retire immediately as a NOP.
            Done    = 1'b1;
            state_d = T0;
          end
        endcase
      end

      T2: begin
        // Only add/sub reach T2; opcode bit 0 selects subtract.
        Rout    = onehot8(ry_s);
        Gin     = 1'b1;
        AddSub  = ir_q[6];
        state_d = T3;
      end

      T3: begin
        Gout    = 1'b1;
        Rin     = onehot8(rx_s);
        Done    = 1'b1;
        state_d = T0;
      end

      default: begin
        state_d = T0;
      end
    endcase
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: directed scenarios followed by
// randomized Run/DIN/Reset traffic, compared every cycle with a reference
// model that keeps the remaining micro-steps of the current instruction as a queue.

module tb_proc_control_unit;

  logic       clock;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic       AddSub;
  logic       Done;

  int errors = 0;
  int checks = 0;

  // Reference model: outputs still to be produced by the instruction in flight,
  // one 22-bit entry {Rin,Rout,DINout,Ain,Gin,Gout,AddSub,Done} per cycle.
  // An empty queue means the unit is idle in the fetch cycle.
  logic [21:0] pend_q[$];

  proc_control_unit dut (
    .clock  (clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .DINout (DINout),
    .Ain    (Ain),
    .Gin    (Gin),
    .Gout   (Gout),
    .AddSub (AddSub),
    .Done   (Done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] mk(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic dinout, input logic ain, input logic gin,
                                     input logic gout, input logic addsub, input logic done);
    return {rin, rout, dinout, ain, gin, gout, addsub, done};
  endfunction

  // Expand an instruction into the cycle-by-cycle strobe list it should produce.
  task automatic push_seq(input logic [8:0] instr);
    logic [7:0] xm;
    logic [7:0] ym;
    logic [2:0] op;
    op = instr[8:6];
    xm = 8'b1 << instr[5:3];
    ym = 8'b1 << instr[2:0];
    if (op == 3'd0) begin
      pend_q.push_back(mk(xm, ym, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else if (op == 3'd1) begin
      pend_q.push_back(mk(xm, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else if (op == 3'd2 || op == 3'd3) begin
      pend_q.push_back(mk(8'h00, xm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      pend_q.push_back(mk(8'h00, ym, 1'b0, 1'b0, 1'b1, 1'b0, (op == 3'd3), 1'b0));
      pend_q.push_back(mk(xm, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    end else begin
      pend_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic cycle(input string tag, input logic rst, input logic run,
                       input logic [8:0] din, input bit full);
    logic [22:0] exp_v;
    logic [22:0] got_v;
    int          bus_drivers;
    @(negedge clock);
    Reset = rst;
    Run   = run;
    DIN   = din;
    #1;
    exp_v = {(pend_q.size() == 0) && run && !rst,
             (pend_q.size() == 0) ? 22'd0 : pend_q[0]};
    got_v = {IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Done};
    if (full) begin
      check_eq(tag, {9'd0, got_v}, {9'd0, exp_v});
      bus_drivers = ((Rout != 8'h00) ? 1 : 0) + int'(Gout) + int'(DINout);
      check_eq("bus_excl", {31'd0, bus_drivers <= 1}, 32'd1);
      check_eq("rin_onehot", {31'd0, $countones(Rin) <= 1}, 32'd1);
      check_eq("rout_onehot", {31'd0, $countones(Rout) <= 1}, 32'd1);
    end else begin
      check_eq("irin_in_reset", {31'd0, IRin}, 32'd0);
    end
    @(posedge clock);
    if (rst) begin
      pend_q.delete();
    end else if (pend_q.size() != 0) begin
      void'(pend_q.pop_front());
    end else if (run) begin
      push_seq(din);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = 9'h000;

    // Reset held three cycles with Run high; state is unknown before the first edge.
    cycle("reset0", 1'b1, 1'b1, 9'h1FF, 1'b0);
    cycle("reset1", 1'b1, 1'b1, 9'h0AA, 1'b1);
    cycle("reset2", 1'b1, 1'b1, 9'h155, 1'b1);
    cycle("idle", 1'b0, 1'b0, 9'h000, 1'b1);
    check_eq("ir_after_reset", {23'd0, dut.ir_q}, 32'd0);

    // mv R2,R5
    cycle("mv_t0", 1'b0, 1'b1, 9'b000_010_101, 1'b1);
    cycle("mv_t1", 1'b0, 1'b0, 9'h000, 1'b1);
    cycle("mv_after", 1'b0, 1'b0, 9'h000, 1'b1);

    // mvi R3 with the immediate on DIN during T1
    cycle("mvi_t0", 1'b0, 1'b1, 9'b001_011_000, 1'b1);
    cycle("mvi_t1", 1'b0, 1'b1, 9'h1A5, 1'b1);
    check_eq("mvi_ir_hold", {23'd0, dut.ir_q}, {23'd0, 9'b001_011_000});
    cycle("mvi_after", 1'b0, 1'b0, 9'h000, 1'b1);

    // sub R1,R6
    cycle("sub_t0", 1'b0, 1'b1, 9'b011_001_110, 1'b1);
    cycle("sub_t1", 1'b0, 1'b1, 9'h0FF, 1'b1);
    cycle("sub_t2", 1'b0, 1'b1, 9'h1FF, 1'b1);
    cycle("sub_t3", 1'b0, 1'b0, 9'h000, 1'b1);
    cycle("sub_after", 1'b0, 1'b0, 9'h000, 1'b1);

    // add R0,R7 aborted by reset in T2, then mv R1,R0
    cycle("add_t0", 1'b0, 1'b1, 9'b010_000_111, 1'b1);
    cycle("add_t1", 1'b0, 1'b0, 9'h000, 1'b1);
    cycle("add_t2_rst", 1'b1, 1'b1, 9'h000, 1'b1);
    cycle("abort_idle", 1'b0, 1'b0, 9'h000, 1'b1);
    check_eq("ir_after_abort", {23'd0, dut.ir_q}, 32'd0);
    cycle("mv2_t0", 1'b0, 1'b1, 9'b000_001_000, 1'b1);
    cycle("mv2_t1", 1'b0, 1'b0, 9'h000, 1'b1);
    cycle("mv2_after", 1'b0, 1'b0, 9'h000, 1'b1);

    // Back-to-back with Run held high: mv, NOP, mv
    cycle("b2b_c1", 1'b0, 1'b1, 9'b000_011_100, 1'b1);
    cycle("b2b_c2", 1'b0, 1'b1, 9'h1C3, 1'b1);
    cycle("b2b_c3", 1'b0, 1'b1, 9'b100_000_000, 1'b1);
    cycle("b2b_c4", 1'b0, 1'b1, 9'h03C, 1'b1);
    cycle("b2b_c5", 1'b0, 1'b1, 9'b000_111_111, 1'b1);
    cycle("b2b_c6", 1'b0, 1'b1, 9'h0F0, 1'b1);
    cycle("b2b_c7", 1'b0, 1'b0, 9'h000, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      cycle("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
            9'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
